act_compressor: RTL and testbench

ACT_COMPRESSOR -- requirements
Module: act_compressor

---
 rtl/act_compressor.sv | 129 ++++++++++++
 tb/tb_act_compressor.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_compressor.sv
// Zero-skipping activation compressor: each dense block becomes one flag word
// plus the packed stream of its nonzero bytes, with occupancy tracking of both buffers.
module act_compressor #(
  parameter int BLOCK_DEPTH = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int ACT_AW      = 10,
  parameter int FLG_AW      = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic [BLOCK_DEPTH*DATA_WIDTH-1:0] in_dat,
  output logic                              flg_wr_en,
  output logic [FLG_AW-1:0]                 flg_wr_addr,
  output logic [BLOCK_DEPTH-1:0]            flg_wr_dat,
  output logic                              act_wr_en,
  output logic [ACT_AW-1:0]                 act_wr_addr,
  output logic [DATA_WIDTH-1:0]             act_wr_dat,
  input  logic                              flg_rd_en,
  input  logic                              act_rd_en,
  output logic                              flg_val,
  output logic                              act_val
);

  localparam int              CW        = $clog2(BLOCK_DEPTH) + 1;
  localparam logic [FLG_AW:0] FLG_DEPTH = {1'b1, {FLG_AW{1'b0}}};
  localparam logic [ACT_AW:0] ACT_DEPTH = {1'b1, {ACT_AW{1'b0}}};
  localparam logic [FLG_AW:0] FLG_ONE   = (FLG_AW+1)'(1);
  localparam logic [ACT_AW:0] ACT_ONE   = (ACT_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, WAITSPC, PACK} state_t;

  state_t                            state;
  logic [BLOCK_DEPTH*DATA_WIDTH-1:0] blk_dat;
  logic [BLOCK_DEPTH-1:0]            blk_flag;
  logic [BLOCK_DEPTH-1:0]            blk_mask;
  logic [BLOCK_DEPTH-1:0]            mask_next;
  logic [BLOCK_DEPTH-1:0]            in_flag;
  logic [CW-1:0]                     blk_cnt;
  logic [CW-1:0]                     in_cnt;
  logic [FLG_AW:0]                   flg_occ;
  logic [ACT_AW:0]                   act_occ;
  logic [ACT_AW:0]                   act_free;
  logic [DATA_WIDTH-1:0]             act_sel;
  logic                              space_ok;
  logic                              flg_pop;
  logic                              act_pop;

  always_comb begin
    in_flag = '0;
    in_cnt  = '0;
    for (int i = 0; i < BLOCK_DEPTH; i++) begin
      in_flag[i] = |in_dat[i*DATA_WIDTH +: DATA_WIDTH];
      in_cnt     = in_cnt + CW'(in_flag[i]);
    end
  end

  // Lowest remaining flag bit selects the byte; clearing it walks indices upward.
  always_comb begin
    act_sel = '0;
    for (int i = BLOCK_DEPTH - 1; i >= 0; i--)
      if (blk_mask[i]) act_sel = blk_dat[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign mask_next = blk_mask & (blk_mask - BLOCK_DEPTH'(1));

  // Space is judged on registered occupancy, so a same-cycle pop only helps next cycle.
  assign act_free = ACT_DEPTH - act_occ;
  assign space_ok = (flg_occ < FLG_DEPTH) && (32'(act_free) >= 32'(blk_cnt));

  assign in_rdy     = (state == IDLE);
  assign flg_wr_en  = (state == WAITSPC) && space_ok;
  assign act_wr_en  = (state == PACK);
  assign flg_wr_dat = flg_wr_en ? blk_flag : '0;
  assign act_wr_dat = act_wr_en ? act_sel : '0;

  assign flg_pop = flg_rd_en && (flg_occ != '0);
  assign act_pop = act_rd_en && (act_occ != '0);
  assign flg_val = (flg_occ != '0);
  assign act_val = (act_occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      blk_dat  <= '0;
      blk_flag <= '0;
      blk_mask <= '0;
      blk_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            blk_dat  <= in_dat;
            blk_flag <= in_flag;
            blk_mask <= in_flag;
            blk_cnt  <= in_cnt;
            state    <= WAITSPC;
          end
        end
        WAITSPC: begin
          if (space_ok) state <= (blk_cnt != '0) ? PACK : IDLE;
        end
        PACK: begin
          blk_mask <= mask_next;
          if (mask_next == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flg_wr_addr <= '0;
      act_wr_addr <= '0;
      flg_occ     <= '0;
      act_occ     <= '0;
    end else begin
      if (flg_wr_en) flg_wr_addr <= flg_wr_addr + FLG_AW'(1);
      if (act_wr_en) act_wr_addr <= act_wr_addr + ACT_AW'(1);
      if (flg_wr_en && !flg_pop)      flg_occ <= flg_occ + FLG_ONE;
      else if (!flg_wr_en && flg_pop) flg_occ <= flg_occ - FLG_ONE;
      if (act_wr_en && !act_pop)      act_occ <= act_occ + ACT_ONE;
      else if (!act_wr_en && act_pop) act_occ <= act_occ - ACT_ONE;
    end
  end

endmodule

// File: tb/tb_act_compressor.sv
// Scoreboard bench for act_compressor: stimulus pushes expected buffer writes,
// a negedge monitor pops and compares them and tracks buffer occupancy.
module tb_act_compressor;

  localparam int BD     = 32;
  localparam int DW     = 8;
  localparam int AAW    = 10;
  localparam int FAW    = 6;
  localparam int FDEPTH = 64;
  localparam int ADEPTH = 1024;

  typedef logic [BD*DW-1:0] blk_t;
  typedef struct {
    int          addr;
    logic [63:0] dat;
    int          cyc;
  } exp_t;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_val    = 1'b0;
  logic           flg_rd_en = 1'b0;
  logic           act_rd_en = 1'b0;
  blk_t           in_dat    = '0;
  logic           in_rdy;
  logic           flg_wr_en;
  logic [FAW-1:0] flg_wr_addr;
  logic [BD-1:0]  flg_wr_dat;
  logic           act_wr_en;
  logic [AAW-1:0] act_wr_addr;
  logic [DW-1:0]  act_wr_dat;
  logic           flg_val;
  logic           act_val;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb_flg[$];
  exp_t sb_act[$];
  int   m_flg_occ = 0;
  int   m_act_occ = 0;
  int   m_faddr = 0;
  int   m_aaddr = 0;
  bit   rand_on = 0;

  act_compressor #(.BLOCK_DEPTH(BD), .DATA_WIDTH(DW), .ACT_AW(AAW), .FLG_AW(FAW)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy), .in_dat(in_dat),
    .flg_wr_en(flg_wr_en), .flg_wr_addr(flg_wr_addr), .flg_wr_dat(flg_wr_dat),
    .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_dat(act_wr_dat),
    .flg_rd_en(flg_rd_en), .act_rd_en(act_rd_en), .flg_val(flg_val), .act_val(act_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic blk_t rand_blk(input int pct);
    blk_t b = '0;
    for (int i = 0; i < BD; i++)
      if ($urandom_range(0, 99) < pct) b[i*DW +: DW] = DW'($urandom_range(1, 255));
    return b;
  endfunction

  function automatic int count_nz(input blk_t b);
    int n = 0;
    for (int i = 0; i < BD; i++) if (b[i*DW +: DW] != 0) n++;
    return n;
  endfunction

  // Monitor: compare every buffer write against the scoreboard, track occupancy.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("flg_val", 64'(flg_val), 64'(m_flg_occ != 0));
      chk("act_val", 64'(act_val), 64'(m_act_occ != 0));
      if (flg_wr_en) begin
        chk("flg_room", 64'(m_flg_occ < FDEPTH), 64'(1));
        chk("flg_sb_nonempty", 64'(sb_flg.size() != 0), 64'(1));
        if (sb_flg.size() != 0) begin
          e = sb_flg.pop_front();
          chk("flg_addr", 64'(flg_wr_addr), 64'(e.addr));
          chk("flg_dat", 64'(flg_wr_dat), e.dat);
          if (e.cyc != -1) chk("flg_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
      if (act_wr_en) begin
        chk("act_room", 64'(m_act_occ < ADEPTH), 64'(1));
        chk("act_sb_nonempty", 64'(sb_act.size() != 0), 64'(1));
        if (sb_act.size() != 0) begin
          e = sb_act.pop_front();
          chk("act_addr", 64'(act_wr_addr), 64'(e.addr));
          chk("act_dat", 64'(act_wr_dat), e.dat);
          if (e.cyc != -1) chk("act_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
      m_flg_occ += int'(flg_wr_en) - int'(flg_rd_en && m_flg_occ > 0);
      m_act_occ += int'(act_wr_en) - int'(act_rd_en && m_act_occ > 0);
    end
  end

  task automatic wait_rdy(output int rdy_cyc);
    int n = 0;
    @(negedge clk);
    while (!in_rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_in_time", 64'(in_rdy), 64'(1));
    rdy_cyc = cyc;
  endtask

  // mode 0: no timing, 1: nominal timing, 2: must not be written until released
  task automatic send(input blk_t blk, input int mode, input bit wait_done,
                      output int h, output int rdy_cyc);
    exp_t          e;
    int            k = 0;
    int            r;
    logic [BD-1:0] f = '0;
    blk_t          junk;
    wait_rdy(r);
    in_val = 1'b1;
    in_dat = blk;
    h = cyc + 1;
    for (int i = 0; i < BD; i++) f[i] = (blk[i*DW +: DW] != 0);
    e.addr = m_faddr;
    e.dat  = 64'(f);
    e.cyc  = (mode == 1) ? h : ((mode == 2) ? -2 : -1);
    sb_flg.push_back(e);
    m_faddr = (m_faddr + 1) % FDEPTH;
    for (int i = 0; i < BD; i++) begin
      if (blk[i*DW +: DW] != 0) begin
        e.addr = m_aaddr;
        e.dat  = 64'(blk[i*DW +: DW]);
        e.cyc  = (mode == 1) ? h + 1 + k : ((mode == 2) ? -2 : -1);
        sb_act.push_back(e);
        m_aaddr = (m_aaddr + 1) % ADEPTH;
        k++;
      end
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
    for (int i = 0; i < BD*DW/32; i++) junk[i*32 +: 32] = $urandom;
    in_dat = junk;
    rdy_cyc = -1;
    if (wait_done) wait_rdy(rdy_cyc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_val = 1'b0;
    flg_rd_en = 1'b0;
    act_rd_en = 1'b0;
    sb_flg.delete();
    sb_act.delete();
    m_flg_occ = 0;
    m_act_occ = 0;
    m_faddr = 0;
    m_aaddr = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'(1));
    chk("rst_flg_wr_en", 64'(flg_wr_en), 64'(0));
    chk("rst_act_wr_en", 64'(act_wr_en), 64'(0));
    chk("rst_flg_addr", 64'(flg_wr_addr), 64'(0));
    chk("rst_act_addr", 64'(act_wr_addr), 64'(0));
    chk("rst_flg_dat", 64'(flg_wr_dat), 64'(0));
    chk("rst_act_dat", 64'(act_wr_dat), 64'(0));
    chk("rst_flg_val", 64'(flg_val), 64'(0));
    chk("rst_act_val", 64'(act_val), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", 64'(in_rdy), 64'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t blk;
    exp_t e;
    int   h, r, p, n;

    do_reset();

    // Sparse block: bytes 1, 3, 31 nonzero
    blk = '0;
    blk[1*DW +: DW]  = 8'h11;
    blk[3*DW +: DW]  = 8'h22;
    blk[31*DW +: DW] = 8'h33;
    send(blk, 1, 1, h, r);
    chk("rdy_latency_sparse", 64'(r), 64'(h + 4));
    for (int i = 0; i < 6; i++) begin
      blk = rand_blk($urandom_range(0, 100));
      send(blk, 1, 1, h, r);
      chk("rdy_latency_rand", 64'(r), 64'(h + count_nz(blk) + 1));
    end

    // All-zero block
    do_reset();
    send('0, 1, 1, h, r);
    chk("rdy_latency_zero", 64'(r), 64'(h + 1));
    chk("act_val_zero_blk", 64'(act_val), 64'(0));

    // Flag buffer full, then a single pop releases the waiting block
    do_reset();
    for (int i = 0; i < FDEPTH; i++) send('0, 1, 1, h, r);
    send('0, 2, 0, h, r);
    repeat (10) @(posedge clk);
    #1;
    chk("flg_stall_pending", 64'(sb_flg.size()), 64'(1));
    flg_rd_en = 1'b1;
    p = cyc;
    if (sb_flg.size() == 1) begin
      e = sb_flg[0];
      e.cyc = p + 1;
      sb_flg[0] = e;
    end
    @(posedge clk);
    #1;
    flg_rd_en = 1'b0;
    wait_rdy(r);
    chk("flg_resume_done", 64'(sb_flg.size()), 64'(0));

    // Act buffer at 1010 entries, N=32 stalls until 18 pops, addresses wrap
    do_reset();
    for (int i = 0; i < 31; i++) send(rand_blk(100), 1, 1, h, r);
    blk = rand_blk(100);
    for (int i = 18; i < BD; i++) blk[i*DW +: DW] = '0;
    send(blk, 1, 1, h, r);
    send(rand_blk(100), 2, 0, h, r);
    repeat (10) @(posedge clk);
    #1;
    chk("act_stall_pending", 64'(sb_act.size()), 64'(32));
    act_rd_en = 1'b1;
    p = cyc;
    if (sb_flg.size() == 1) begin
      e = sb_flg[0];
      e.cyc = p + 18;
      sb_flg[0] = e;
    end
    for (int k = 0; k < sb_act.size(); k++) begin
      e = sb_act[k];
      e.cyc = p + 19 + k;
      sb_act[k] = e;
    end
    repeat (18) @(posedge clk);
    #1;
    act_rd_en = 1'b0;
    wait_rdy(r);
    chk("act_resume_done", 64'(sb_act.size()), 64'(0));

    // Simultaneous write and pop, then pops against an empty buffer
    do_reset();
    blk = '0;
    for (int i = 0; i < 5; i++) blk[i*DW +: DW] = DW'($urandom_range(1, 255));
    send(blk, 1, 1, h, r);
    blk = '0;
    blk[4*DW +: DW]  = 8'h5a;
    blk[9*DW +: DW]  = 8'h01;
    blk[20*DW +: DW] = 8'hff;
    send(blk, 1, 0, h, r);
    @(posedge clk);
    #1;
    act_rd_en = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    act_rd_en = 1'b0;
    @(negedge clk);
    chk("act_val_occ_one", 64'(act_val), 64'(1));
    @(posedge clk);
    #1;
    act_rd_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    act_rd_en = 1'b0;
    @(negedge clk);
    chk("act_val_empty", 64'(act_val), 64'(0));
    blk = '0;
    blk[7*DW +: DW] = 8'h3c;
    send(blk, 1, 1, h, r);
    chk("act_val_one_after_empty_pops", 64'(act_val), 64'(1));
    @(posedge clk);
    #1;
    act_rd_en = 1'b1;
    @(posedge clk);
    #1;
    act_rd_en = 1'b0;
    @(negedge clk);
    chk("act_val_drained", 64'(act_val), 64'(0));

    // Reset in the middle of packing a full block
    do_reset();
    send(rand_blk(100), 1, 0, h, r);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("abort_remaining", 64'(sb_act.size()), 64'(30));
    @(negedge clk);
    chk("abort_act_wr_en", 64'(act_wr_en), 64'(0));
    chk("abort_act_addr", 64'(act_wr_addr), 64'(0));
    chk("abort_act_val", 64'(act_val), 64'(0));
    do_reset();
    send(rand_blk(50), 1, 1, h, r);

    // Randomized traffic with random downstream pops
    do_reset();
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          flg_rd_en = ($urandom_range(0, 3) != 0);
          act_rd_en = ($urandom_range(0, 1) != 0);
        end
        flg_rd_en = 1'b0;
        act_rd_en = 1'b0;
      end
    join_none
    for (int i = 0; i < 40; i++) send(rand_blk($urandom_range(0, 100)), 0, 0, h, r);
    n = 0;
    while ((sb_flg.size() != 0 || sb_act.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_flg", 64'(sb_flg.size()), 64'(0));
    chk("drain_act", 64'(sb_act.size()), 64'(0));
    rand_on = 0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
